// File: rtl/mc_pkg.sv
// Purpose: shared encodings for the multicycle MIPS control FSM (states, opcodes, mux selects, control vector).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

   // FSM state encodings. Kept as plain 4-bit constants so they match the state_out debug bus.
   localparam logic [3:0] ST_FETCH     = 4'd0;
   localparam logic [3:0] ST_DECODE    = 4'd1;
   localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
   localparam logic [3:0] ST_MEM_READ  = 4'd3;
   localparam logic [3:0] ST_MEM_WB    = 4'd4;
   localparam logic [3:0] ST_MEM_WRITE = 4'd5;
   localparam logic [3:0] ST_R_EXEC    = 4'd6;
   localparam logic [3:0] ST_R_WB      = 4'd7;
   localparam logic [3:0] ST_BRANCH    = 4'd8;
   localparam logic [3:0] ST_JUMP      = 4'd9;
   localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
   localparam logic [3:0] ST_ADDI_WB   = 4'd11;
   localparam logic [3:0] ST_HALT      = 4'd12;

   // IR[31:26] opcodes understood by this controller.
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // ALU operation selects.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B-operand selects.
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PC next-value selects.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Full datapath control vector driven every cycle.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // States that own the memory port and therefore wait on mem_ready.
   function automatic logic is_mem_state(input logic [3:0] st);
      return (st == ST_FETCH) || (st == ST_MEM_READ) || (st == ST_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Purpose: combinational state -> datapath control vector decode (Moore, plus FETCH completion gating).
// Latency: 0 cycles, purely combinational.
// Backpressure: ir_write/pc_write in FETCH only fire on mem_ready; every other output ignores it.
module mc_ctrl_decode
   import mc_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   // Decode one state into its control vector; anything unlisted (including HALT) is all-zero.
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.i_or_d    = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // IR and PC+4 are only committed in the cycle the read actually completes.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         ST_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_ADDR, ST_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_dst    = 1'b0;
         end
         ST_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         ST_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_FUNCT;
         end
         ST_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         ST_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle MIPS main control FSM with memory wait/timeout and sticky error flags; MC_PERF_CNT_EN adds perf counters.
// Latency: R/addi/sw 4 cycles, lw 5, beq/j 3 with mem_ready held high; each memory state adds one cycle per mem_ready=0.
// Backpressure: memory states hold their requests until mem_ready; TIMEOUT waiting cycles halt the FSM with bus_err.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state_out,
`ifdef MC_PERF_CNT_EN
   output logic [31:0] perf_cycles,
   output logic [31:0] perf_instrs,
`endif
   output logic        illegal_op,
   output logic        bus_err
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   logic [3:0]       state_q;
   logic [3:0]       state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             illegal_hit;
   logic             timeout_hit;
   logic             illegal_q;
   logic             bus_err_q;
   ctrl_t            ctrl_dec;
   ctrl_t            ctrl_o;

   // The beq decision (pc_write_cond & zero) is made in the datapath's PC-enable logic.
   logic unused_zero;
   assign unused_zero = zero;

   // Next-state selection; a memory state that has waited TIMEOUT cycles overrides everything with HALT.
   always_comb begin
      state_d     = state_q;
      illegal_hit = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = ST_MEM_ADDR;
               OP_R:         state_d = ST_R_EXEC;
               OP_BEQ:       state_d = ST_BRANCH;
               OP_J:         state_d = ST_JUMP;
               OP_ADDI:      state_d = ST_ADDI_EXEC;
               default: begin
                  // Unknown opcode retires as a NOP; PC+4 was already taken in FETCH.
                  state_d     = ST_FETCH;
                  illegal_hit = 1'b1;
               end
            endcase
         end
         ST_MEM_ADDR:  state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
         ST_MEM_WB,
         ST_R_WB,
         ST_ADDI_WB,
         ST_BRANCH,
         ST_JUMP:      state_d = ST_FETCH;
         ST_R_EXEC:    state_d = ST_R_WB;
         ST_ADDI_EXEC: state_d = ST_ADDI_WB;
         ST_HALT:      state_d = ST_HALT;
         default:      state_d = ST_FETCH;
      endcase
      if (is_mem_state(state_q) && !mem_ready && (wait_cnt == WAIT_LAST)) begin
         state_d     = ST_HALT;
         timeout_hit = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_FETCH;
      else      state_q <= state_d;
   end

   // Wait counter: restarts on any state change or completed access, counts stalled memory cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               wait_cnt <= '0;
      else if ((state_d != state_q) || mem_ready) wait_cnt <= '0;
      else if (is_mem_state(state_q))         wait_cnt <= wait_cnt + 1'b1;
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         if (illegal_hit) illegal_q <= 1'b1;
         if (timeout_hit) bus_err_q <= 1'b1;
      end
   end

   mc_ctrl_decode u_decode (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_dec)
   );

   // Reset kills every control immediately, including an in-flight memory request.
   assign ctrl_o = rst ? ctrl_dec : CTRL_IDLE;

   assign pc_write      = ctrl_o.pc_write;
   assign pc_write_cond = ctrl_o.pc_write_cond;
   assign i_or_d        = ctrl_o.i_or_d;
   assign mem_read      = ctrl_o.mem_read;
   assign mem_write     = ctrl_o.mem_write;
   assign ir_write      = ctrl_o.ir_write;
   assign mem_to_reg    = ctrl_o.mem_to_reg;
   assign reg_dst       = ctrl_o.reg_dst;
   assign reg_write     = ctrl_o.reg_write;
   assign alu_src_a     = ctrl_o.alu_src_a;
   assign alu_src_b     = ctrl_o.alu_src_b;
   assign alu_op        = ctrl_o.alu_op;
   assign pc_source     = ctrl_o.pc_source;
   assign state_out     = state_q;
   assign illegal_op    = illegal_q;
   assign bus_err       = bus_err_q;

`ifdef MC_PERF_CNT_EN
   // Cycle count excludes HALT; an instruction retires on every entry into FETCH from another state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles <= '0;
         perf_instrs <= '0;
      end else begin
         if (state_q != ST_HALT) perf_cycles <= perf_cycles + 32'd1;
         if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) perf_instrs <= perf_instrs + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: scoreboard bench for multicycle_ctrl; directed instruction sequences with hand-written control vectors.
// Latency: one expected entry per clock cycle, compared on the falling edge of that cycle.
// Backpressure: mem_ready stalls, timeout-to-HALT and asynchronous reset during an access are exercised.
module tb_multicycle_ctrl;
   import mc_pkg::*;

   // Control vector packing: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   //                          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
   localparam logic [15:0] C_NONE      = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_FETCH_RDY = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
   localparam logic [15:0] C_FETCH_W   = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
   localparam logic [15:0] C_DECODE    = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
   localparam logic [15:0] C_ADDR      = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [15:0] C_MEMRD     = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_MEMWB     = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
   localparam logic [15:0] C_MEMWR     = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_REXEC     = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
   localparam logic [15:0] C_RWB       = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
   localparam logic [15:0] C_BRANCH    = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [15:0] C_JUMP      = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
   localparam logic [15:0] C_ADDIWB    = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state_out;
   logic        illegal_op, bus_err;
`ifdef MC_PERF_CNT_EN
   logic [31:0] perf_cycles, perf_instrs;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   string       name_q[$];
   logic [31:0] exp_q[$];
   int          cyc_q[$];

   logic [15:0] ctrl_act;
   assign ctrl_act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   multicycle_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .state_out     (state_out),
`ifdef MC_PERF_CNT_EN
      .perf_cycles   (perf_cycles),
      .perf_instrs   (perf_instrs),
`endif
      .illegal_op    (illegal_op),
      .bus_err       (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Queue the expected {state, controls, illegal_op, bus_err} for the current cycle, then advance.
   task automatic step(input string nm, input logic [3:0] st, input logic [15:0] c,
                       input logic ill, input logic berr);
      name_q.push_back(nm);
      exp_q.push_back({10'd0, st, c, ill, berr});
      cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
   endtask

   // Monitor: on every falling edge, retire all expectations queued for this cycle.
   string       mon_nm;
   logic [31:0] mon_exp;
   always @(negedge clk) begin
      while (cyc_q.size() != 0 && cyc_q[0] <= cyc) begin
         mon_nm  = name_q.pop_front();
         mon_exp = exp_q.pop_front();
         cyc_q.delete(0);
         check(mon_nm, {10'd0, state_out, ctrl_act, illegal_op, bus_err}, mon_exp);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      step("reset_hold", ST_FETCH, C_NONE, 1'b0, 1'b0);

      // Three R-type instructions with memory always ready.
      rst = 1'b1; mem_ready = 1'b1; opcode = OP_R;
      for (int i = 0; i < 3; i++) begin
         step($sformatf("r%0d_fetch", i),  ST_FETCH,  C_FETCH_RDY, 1'b0, 1'b0);
         step($sformatf("r%0d_decode", i), ST_DECODE, C_DECODE,    1'b0, 1'b0);
         step($sformatf("r%0d_exec", i),   ST_R_EXEC, C_REXEC,     1'b0, 1'b0);
         step($sformatf("r%0d_wb", i),     ST_R_WB,   C_RWB,       1'b0, 1'b0);
      end
`ifdef MC_PERF_CNT_EN
      check("perf_instrs", perf_instrs, 32'd3);
      check("perf_cycles", perf_cycles, 32'd12);
`endif

      // lw with three stalled MEM_READ cycles.
      opcode = OP_LW;
      step("lw_fetch",  ST_FETCH,    C_FETCH_RDY, 1'b0, 1'b0);
      step("lw_decode", ST_DECODE,   C_DECODE,    1'b0, 1'b0);
      step("lw_addr",   ST_MEM_ADDR, C_ADDR,      1'b0, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step($sformatf("lw_wait%0d", i), ST_MEM_READ, C_MEMRD, 1'b0, 1'b0);
      mem_ready = 1'b1;
      step("lw_read_done", ST_MEM_READ, C_MEMRD, 1'b0, 1'b0);
      step("lw_wb",        ST_MEM_WB,   C_MEMWB, 1'b0, 1'b0);

      // sw, memory ready.
      opcode = OP_SW;
      step("sw_fetch",  ST_FETCH,     C_FETCH_RDY, 1'b0, 1'b0);
      step("sw_decode", ST_DECODE,    C_DECODE,    1'b0, 1'b0);
      step("sw_addr",   ST_MEM_ADDR,  C_ADDR,      1'b0, 1'b0);
      step("sw_write",  ST_MEM_WRITE, C_MEMWR,     1'b0, 1'b0);

      // beq with zero=1, preceded by a two-cycle fetch stall.
      opcode = OP_BEQ; zero = 1'b1; mem_ready = 1'b0;
      step("beq_fetch_w0", ST_FETCH, C_FETCH_W, 1'b0, 1'b0);
      step("beq_fetch_w1", ST_FETCH, C_FETCH_W, 1'b0, 1'b0);
      mem_ready = 1'b1;
      step("beq_fetch",  ST_FETCH,  C_FETCH_RDY, 1'b0, 1'b0);
      step("beq_decode", ST_DECODE, C_DECODE,    1'b0, 1'b0);
      step("beq_branch", ST_BRANCH, C_BRANCH,    1'b0, 1'b0);

      // j.
      opcode = OP_J; zero = 1'b0;
      step("j_fetch",  ST_FETCH,  C_FETCH_RDY, 1'b0, 1'b0);
      step("j_decode", ST_DECODE, C_DECODE,    1'b0, 1'b0);
      step("j_jump",   ST_JUMP,   C_JUMP,      1'b0, 1'b0);

      // Unsupported opcode retires as NOP and sets the sticky flag.
      opcode = 6'h3F;
      step("ill_fetch",  ST_FETCH,  C_FETCH_RDY, 1'b0, 1'b0);
      step("ill_decode", ST_DECODE, C_DECODE,    1'b0, 1'b0);

      // addi; illegal_op must stay set.
      opcode = OP_ADDI;
      step("addi_fetch",  ST_FETCH,     C_FETCH_RDY, 1'b1, 1'b0);
      step("addi_decode", ST_DECODE,    C_DECODE,    1'b1, 1'b0);
      step("addi_exec",   ST_ADDI_EXEC, C_ADDR,      1'b1, 1'b0);
      step("addi_wb",     ST_ADDI_WB,   C_ADDIWB,    1'b1, 1'b0);

      // Fetch never completes: 16 waiting cycles, then HALT for good.
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) step($sformatf("to_wait%0d", i), ST_FETCH, C_FETCH_W, 1'b1, 1'b0);
      step("halt0", ST_HALT, C_NONE, 1'b1, 1'b1);
      mem_ready = 1'b1;
      step("halt1", ST_HALT, C_NONE, 1'b1, 1'b1);
      step("halt2", ST_HALT, C_NONE, 1'b1, 1'b1);

      // Reset pulse out of HALT clears both sticky flags without a clock edge.
      rst = 1'b0;
      #1;
      check("halt_rst_bus_err_async", {31'd0, bus_err}, 32'd0);
      step("halt_rst", ST_FETCH, C_NONE, 1'b0, 1'b0);

      // Reset in the middle of a stalled store drops mem_write immediately.
      rst = 1'b1; mem_ready = 1'b1; opcode = OP_SW;
      step("sw2_fetch",  ST_FETCH,    C_FETCH_RDY, 1'b0, 1'b0);
      step("sw2_decode", ST_DECODE,   C_DECODE,    1'b0, 1'b0);
      step("sw2_addr",   ST_MEM_ADDR, C_ADDR,      1'b0, 1'b0);
      mem_ready = 1'b0;
      step("sw2_wait",   ST_MEM_WRITE, C_MEMWR,    1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check("sw2_rst_mem_write_async", {31'd0, mem_write}, 32'd0);
      check("sw2_rst_state_async", {28'd0, state_out}, {28'd0, ST_FETCH});
      step("sw2_rst", ST_FETCH, C_NONE, 1'b0, 1'b0);

      // Restart cleanly with a jump.
      rst = 1'b1; mem_ready = 1'b1; opcode = OP_J;
      step("j2_fetch",  ST_FETCH,  C_FETCH_RDY, 1'b0, 1'b0);
      step("j2_decode", ST_DECODE, C_DECODE,    1'b0, 1'b0);
      step("j2_jump",   ST_JUMP,   C_JUMP,      1'b0, 1'b0);
      step("j2_back",   ST_FETCH,  C_FETCH_RDY, 1'b0, 1'b0);

      @(negedge clk); #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
